// File: rtl/fetch_pc_unit_if.sv
// Instruction SRAM request/response channel between the fetch unit and the memory side.
interface fetch_pc_unit_if;
    localparam int unsigned XLEN = 32;

    logic            inst_req;
    logic [XLEN-1:0] inst_addr;
    logic            inst_addr_ok;
    logic            inst_data_ok;
    logic [XLEN-1:0] inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage plus IF/ID register: owns the PC, runs the SRAM handshake and applies
// decode-stage redirects with MIPS delay-slot semantics.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallD,
    input  logic                   flushD,
    input  logic                   pcsrcD,
    input  logic [31:0]            branch_targetD,
    input  logic                   jumpD,
    input  logic [31:0]            jump_targetD,
    input  logic                   excep_flush,
    input  logic [31:0]            excep_pc,
    fetch_pc_unit_if.master        inst,
    output logic [31:0]            pcF,
    output logic [31:0]            instrD,
    output logic [31:0]            pcD,
    output logic [31:0]            pcplus4D,
    output logic                   validD,
    output logic                   fetch_busy
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

    state_t          state;
    logic [XLEN-1:0] hold_buf;
    logic [XLEN-1:0] pend_pc;
    logic            pend_valid;

    logic            advance;
    logic            redir_accept;
    logic [XLEN-1:0] redir_target;
    logic [XLEN-1:0] fetch_word;
    logic [XLEN-1:0] next_pc;

    // Delivery, redirect and next-PC selection for the current cycle.
    always_comb begin
        redir_accept = validD & ~stallD & (jumpD | pcsrcD);
        redir_target = jumpD ? jump_targetD : branch_targetD;
        advance      = ~excep_flush & ~stallD &
                       ((state == HOLD) | ((state == WAIT) & inst.inst_data_ok));
        fetch_word   = (state == HOLD) ? hold_buf : inst.inst_rdata;
        next_pc      = pcF + XLEN'(4);
        if (pend_valid) begin
            next_pc = pend_pc;
        end else if (redir_accept) begin
            next_pc = redir_target;
        end
        fetch_busy   = ~((state == HOLD) | ((state == WAIT) & inst.inst_data_ok));
    end

    assign inst.inst_req  = ~rst & (state == REQ);
    assign inst.inst_addr = pcF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            pcF        <= RESET_PC;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            hold_buf   <= '0;
            instrD     <= '0;
            pcD        <= '0;
            pcplus4D   <= '0;
            validD     <= 1'b0;
        end else if (excep_flush) begin
            pcF        <= excep_pc;
            pend_valid <= 1'b0;
            instrD     <= '0;
            validD     <= 1'b0;
            // A response already in flight must be swallowed before requesting again.
            case (state)
                REQ:  state <= inst.inst_addr_ok ? DROP : REQ;
                WAIT: state <= inst.inst_data_ok ? REQ : DROP;
                HOLD: state <= REQ;
                DROP: state <= inst.inst_data_ok ? REQ : DROP;
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ:  if (inst.inst_addr_ok) state <= WAIT;
                WAIT: if (inst.inst_data_ok) begin
                          if (stallD) begin
                              hold_buf <= inst.inst_rdata;
                              state    <= HOLD;
                          end else begin
                              state <= REQ;
                          end
                      end
                HOLD: if (!stallD) state <= REQ;
                DROP: if (inst.inst_data_ok) state <= REQ;
                default: state <= REQ;
            endcase

            // A redirect seen while the delay slot is still in flight waits in pend_pc.
            if (advance) begin
                pcF        <= next_pc;
                pend_valid <= 1'b0;
            end else if (redir_accept) begin
                pend_valid <= 1'b1;
                pend_pc    <= redir_target;
            end

            if (!stallD) begin
                if (advance && !flushD) begin
                    instrD   <= fetch_word;
                    pcD      <= pcF;
                    pcplus4D <= pcF + XLEN'(4);
                    validD   <= 1'b1;
                end else begin
                    instrD <= '0;
                    validD <= 1'b0;
                end
            end
        end
    end
endmodule
